// File: rtl/onewire_if.sv
// Command/response channel between host logic and the 1-Wire byte master.
// Valid/ready: a command transfers on a cycle where cmd_valid && cmd_ready;
// rsp_valid is a single-cycle pulse that the host must take (no back-pressure).
interface onewire_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;

   // host side
   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, busy
   );

   // 1-Wire master side
   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus master: bus reset/presence, write byte, read byte.
// Drives an open-drain pad (pin_data fixed 0, pin_enable pulls the bus low).
// All slot timings are measured from the first SLOT_LOW cycle of each slot.
module onewire_master #(
   parameter int TICKS_PER_US = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   onewire_if.slave   bus,
   output logic       pin_data,
   output logic       pin_enable,
   input  logic       pin_in,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RST_LOW, S_RST_WAIT, S_RST_REC, S_SLOT_LOW, S_SLOT_REL, S_DONE
   } state_t;

   localparam int CW = $clog2(480 * TICKS_PER_US);

   // terminal counts (last cycle of each phase, counter starts at 0)
   localparam logic [CW-1:0] C_RST_LOW  = CW'(480 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_RST_WAIT = CW'(70 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_RST_REC  = CW'(410 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_SLOT     = CW'(70 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_LOW_ONE  = CW'(6 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_LOW_ZERO = CW'(60 * TICKS_PER_US - 1);
   localparam logic [CW-1:0] C_SAMPLE   = CW'(15 * TICKS_PER_US);

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      op_q, op_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      rx_q, rx_d;
   logic            pres_q, pres_d;
   logic [7:0]      rsp_q, rsp_d;
   logic            sync1_q, sync2_q;
   logic [CW-1:0]   low_end;

   // two-flop synchroniser for the asynchronous pad input (idle bus = 1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
      end
   end

   // state, counters and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         op_q    <= '0;
         data_q  <= '0;
         rx_q    <= '0;
         pres_q  <= 1'b0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rx_q    <= rx_d;
         pres_q  <= pres_d;
         rsp_q   <= rsp_d;
      end
   end

   // a written 0 holds the bus low for most of the slot; reads and 1s pulse briefly
   assign low_end = (op_q == OP_WRITE && !data_q[bit_q]) ? C_LOW_ZERO : C_LOW_ONE;

   // next-state and datapath updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      op_d    = op_q;
      data_d  = data_q;
      rx_d    = rx_q;
      pres_d  = pres_q;
      rsp_d   = rsp_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d   = bus.cmd_op;
               data_d = bus.cmd_data;
               cnt_d  = '0;
               bit_d  = '0;
               rx_d   = '0;
               case (bus.cmd_op)
                  OP_RESET: state_d = S_RST_LOW;
                  OP_WRITE,
                  OP_READ:  state_d = S_SLOT_LOW;
                  default: begin
                     state_d = S_DONE;
                     rsp_d   = 8'h00;
                  end
               endcase
            end
         end
         S_RST_LOW: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_RST_LOW) begin
               cnt_d   = '0;
               state_d = S_RST_WAIT;
            end
         end
         S_RST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_RST_WAIT) begin
               pres_d  = ~sync2_q;
               cnt_d   = '0;
               state_d = S_RST_REC;
            end
         end
         S_RST_REC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_RST_REC) begin
               cnt_d   = '0;
               rsp_d   = {7'b0, pres_q};
               state_d = S_DONE;
            end
         end
         S_SLOT_LOW, S_SLOT_REL: begin
            // counter runs across both halves so it stays slot-relative
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_SAMPLE) begin
               rx_d = {sync2_q, rx_q[7:1]};
            end
            if (state_q == S_SLOT_LOW && cnt_q == low_end) begin
               state_d = S_SLOT_REL;
            end
            if (state_q == S_SLOT_REL && cnt_q == C_SLOT) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  rsp_d   = rx_q;
                  state_d = S_DONE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = S_SLOT_LOW;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pin_data      = 1'b0;
   assign pin_enable    = (state_q == S_RST_LOW) || (state_q == S_SLOT_LOW);
   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.rsp_data  = rsp_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at TICKS_PER_US=1 (1 cycle = 1 us).
// The bus is modelled as open-drain: low when the master drives or the bench pulls.
module tb_onewire_master;

   localparam int T = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   onewire_if bus_if ();
   logic       pin_data;
   logic       pin_enable;
   logic       pin_in;
   logic       ext_low;
   logic [2:0] dbg_state;

   assign pin_in = ~(pin_enable | ext_low);

   onewire_master #(.TICKS_PER_US(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .pin_data    (pin_data),
      .pin_enable  (pin_enable),
      .pin_in      (pin_in),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_rsp;

   int          en_cycles, rsp_cycle, rsp_cnt, pd_bad, n_pulses;
   int          pw[16];
   int          ps[16];
   logic [7:0]  rsp_seen;
   logic        busy1, ready1;
   int          exp_w[8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // wait for IDLE, then offer one command for exactly one accepting edge
   task automatic start_cmd(input logic [1:0] op, input logic [7:0] data);
      int guard = 0;
      @(negedge clk);
      while (!bus_if.cmd_ready && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_wait", {31'b0, bus_if.cmd_ready}, 1);
      bus_if.cmd_op    = op;
      bus_if.cmd_data  = data;
      bus_if.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus_if.cmd_valid = 1'b0;
   endtask

   // run one command and record bus timing; mode 1 pulls low for k in [a,b],
   // mode 2 pulls low for the first 20 us of every slot selected by mask
   task automatic run_op(input logic [1:0] op, input logic [7:0] data, input int mode,
                         input int a, input int b, input logic [7:0] mask, input int max_k);
      logic prev_en = 1'b0;
      int   s, o;
      start_cmd(op, data);
      en_cycles = 0; rsp_cycle = -1; rsp_cnt = 0; pd_bad = 0; n_pulses = 0;
      rsp_seen = 8'hxx;
      for (int k = 1; k <= max_k; k++) begin
         @(negedge clk);
         if (k == 1) begin
            busy1  = bus_if.busy;
            ready1 = bus_if.cmd_ready;
         end
         if (pin_enable) en_cycles++;
         if (pin_enable && !prev_en && n_pulses < 16) ps[n_pulses] = k;
         if (!pin_enable && prev_en && n_pulses < 16) begin
            pw[n_pulses] = k - ps[n_pulses];
            n_pulses++;
         end
         prev_en = pin_enable;
         if (pin_data) pd_bad++;
         if (bus_if.rsp_valid) begin
            rsp_cnt++;
            if (rsp_cycle < 0) begin
               rsp_cycle = k;
               rsp_seen  = bus_if.rsp_data;
            end
         end
         if (!bus_if.busy && rsp_cnt > 0) break;
         if (mode == 1) begin
            ext_low = (k >= a && k <= b);
         end else if (mode == 2) begin
            s = (k - 1) / 70;
            o = (k - 1) % 70;
            ext_low = (s < 8) && mask[s] && (o < 20);
         end else begin
            ext_low = 1'b0;
         end
      end
      ext_low = 1'b0;
   endtask

   // ---------------- global time limit ----------------
   initial begin
      #2000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int acc, rsps, overlap, pdb, guard;
      exp_w = '{6, 60, 6, 60, 60, 6, 60, 6};
      rst_n = 1'b0;
      ext_low = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 2'b00;
      bus_if.cmd_data  = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_cmd_ready", {31'b0, bus_if.cmd_ready}, 1);
      check("rst_busy", {31'b0, bus_if.busy}, 0);
      check("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 0);
      check("rst_rsp_data", {24'b0, bus_if.rsp_data}, 8'h00);
      check("rst_pin_enable", {31'b0, pin_enable}, 0);
      check("rst_pin_data", {31'b0, pin_data}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // bus reset with a presence pulse
      exp_q.push_back(8'h01);
      run_op(2'b00, 8'h00, 1, 500, 600, 8'h00, 1100);
      check("p_busy_after_accept", {31'b0, busy1}, 1);
      check("p_ready_after_accept", {31'b0, ready1}, 0);
      check("p_low_cycles", en_cycles, 480 * T);
      check("p_low_pulses", n_pulses, 1);
      check("p_low_width", pw[0], 480 * T);
      check("p_rsp_cycle", rsp_cycle, 961 * T);
      check("p_rsp_count", rsp_cnt, 1);
      check("p_pin_data", pd_bad, 0);
      exp_rsp = exp_q.pop_front();
      check("p_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});

      // bus reset, no device answering
      exp_q.push_back(8'h00);
      run_op(2'b00, 8'h00, 0, 0, 0, 8'h00, 1100);
      check("np_low_cycles", en_cycles, 480 * T);
      check("np_rsp_cycle", rsp_cycle, 961 * T);
      exp_rsp = exp_q.pop_front();
      check("np_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});

      // write 0xA5 on an uncontested bus
      exp_q.push_back(8'hA5);
      run_op(2'b01, 8'hA5, 0, 0, 0, 8'h00, 700);
      check("w_pulses", n_pulses, 8);
      for (int i = 0; i < 8; i++) check($sformatf("w_width%0d", i), pw[i], exp_w[i] * T);
      for (int i = 0; i < 7; i++) check($sformatf("w_period%0d", i), ps[i+1] - ps[i], 70 * T);
      check("w_first_low", ps[0], 1);
      check("w_rsp_cycle", rsp_cycle, 561 * T);
      exp_rsp = exp_q.pop_front();
      check("w_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});
      check("w_rsp_hold", {24'b0, bus_if.rsp_data}, 8'hA5);

      // reserved op: no bus activity, immediate response
      exp_q.push_back(8'h00);
      run_op(2'b11, 8'hFF, 0, 0, 0, 8'h00, 20);
      check("r11_rsp_cycle", rsp_cycle, 1);
      check("r11_low_cycles", en_cycles, 0);
      exp_rsp = exp_q.pop_front();
      check("r11_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});

      // read with a device pulling slots 1 and 7 low
      exp_q.push_back(8'h7D);
      run_op(2'b10, 8'h00, 2, 0, 0, 8'h82, 700);
      check("rd_pulses", n_pulses, 8);
      for (int i = 0; i < 8; i++) check($sformatf("rd_width%0d", i), pw[i], 6 * T);
      check("rd_rsp_cycle", rsp_cycle, 561 * T);
      exp_rsp = exp_q.pop_front();
      check("rd_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});

      // reset in the middle of a write (slot 2 of 0x00, bus held low)
      start_cmd(2'b01, 8'h00);
      repeat (200) @(negedge clk);
      check("ab_low_before", {31'b0, pin_enable}, 1);
      rst_n = 1'b0;
      #1;
      check("ab_release_async", {31'b0, pin_enable}, 0);
      check("ab_ready_in_reset", {31'b0, bus_if.cmd_ready}, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rsps = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_if.rsp_valid) rsps++;
      end
      check("ab_no_rsp", rsps, 0);
      check("ab_ready_after", {31'b0, bus_if.cmd_ready}, 1);

      // normal read after the abort, device pulls slot 0 only
      exp_q.push_back(8'hFE);
      run_op(2'b10, 8'h00, 2, 0, 0, 8'h01, 700);
      check("ar_rsp_cycle", rsp_cycle, 561 * T);
      exp_rsp = exp_q.pop_front();
      check("ar_rsp_data", {24'b0, rsp_seen}, {24'b0, exp_rsp});

      // cmd_valid held high across repeated bus resets
      @(negedge clk);
      bus_if.cmd_op    = 2'b00;
      bus_if.cmd_valid = 1'b1;
      acc = 0; rsps = 0; overlap = 0; pdb = 0;
      for (int i = 0; i < 2000; i++) begin
         if (i > 0) @(negedge clk);
         if (bus_if.cmd_valid && bus_if.cmd_ready) acc++;
         if (bus_if.rsp_valid) rsps++;
         if (bus_if.rsp_valid && bus_if.cmd_ready) overlap++;
         if (pin_data) pdb++;
      end
      bus_if.cmd_valid = 1'b0;
      check("hv_accepts", acc, 3);
      check("hv_rsps", rsps, 2);
      check("hv_overlap", overlap, 0);
      check("hv_pin_data", pdb, 0);
      guard = 0;
      while (bus_if.busy && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("hv_final_idle", {31'b0, bus_if.busy}, 0);
      check("hv_final_rsp", {24'b0, bus_if.rsp_data}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
